hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 177 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: in-order queue of outstanding load destinations plus stall/flush control.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PEND_DEPTH     = 4,
    localparam int PTR_W         = $clog2(PEND_DEPTH),
    localparam int CNT_W         = PTR_W + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic                      id_rs1_used_i,
    input  logic                      id_rs2_used_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic                      ex_mem_read_i,
    input  logic                      ex_advance_i,
    input  logic                      mem_ack_i,
    input  logic                      branch_taken_i,
    output logic                      stall_if_o,
    output logic                      stall_id_o,
    output logic                      stall_ex_o,
    output logic                      bubble_ex_o,
    output logic                      flush_ifid_o,
    output logic [CNT_W-1:0]          pend_count_o,
    output logic                      ack_err_o,
    output logic [31:0]               stall_cycles_o,
    output logic [31:0]               flush_count_o,
    output logic [1:0]                dbg_state_o
);

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_LU_STALL   = 2'd1;
    localparam logic [1:0] ST_FULL_STALL = 2'd2;

    logic [PEND_DEPTH-1:0]     ent_valid;
    logic [REG_ADDR_WIDTH-1:0] ent_rd [PEND_DEPTH];
    logic [PTR_W-1:0]          head;
    logic [PTR_W-1:0]          tail;
    logic [CNT_W-1:0]          count;
    logic                      ack_err;
    logic [1:0]                state_q;
    logic [1:0]                state_d;

    logic full;
    logic pop;
    logic push;
    logic hit_pend;
    logic hit_ex;
    logic full_block;

    assign full       = (count == CNT_W'(PEND_DEPTH));
    assign pop        = mem_ack_i && (count != '0);
    // A branch lifts stall_ex_o even when full; the space term keeps such a push from overwriting a live entry.
    assign push       = ex_mem_read_i && ex_advance_i && !stall_ex_o && (!full || pop);
    assign full_block = ex_mem_read_i && full && !mem_ack_i;
    assign hit_ex     = ex_mem_read_i && (ex_rd_addr_i != '0) &&
                        ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                         (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));

    // Uses current contents, so an entry popped this cycle still blocks its consumer.
    always_comb begin
        hit_pend = 1'b0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] != '0) &&
                ((id_rs1_used_i && (id_rs1_addr_i == ent_rd[i])) ||
                 (id_rs2_used_i && (id_rs2_addr_i == ent_rd[i])))) begin
                hit_pend = 1'b1;
            end
        end
    end

    always_comb begin
        stall_if_o   = 1'b0;
        stall_id_o   = 1'b0;
        stall_ex_o   = 1'b0;
        bubble_ex_o  = 1'b0;
        flush_ifid_o = 1'b0;
        if (rst_i) begin
            stall_if_o = 1'b0;
        end else if (branch_taken_i) begin
            flush_ifid_o = 1'b1;
            bubble_ex_o  = 1'b1;
        end else if (full_block) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
            stall_ex_o = 1'b1;
        end else if (hit_ex || hit_pend) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
        end
    end

    // Pop is applied before push so a simultaneous push into the freed slot (full queue) wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ent_valid <= '0;
            for (int i = 0; i < PEND_DEPTH; i++) begin
                ent_rd[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            if (push) begin
                ent_valid[tail] <= 1'b1;
                ent_rd[tail]    <= ex_rd_addr_i;
                tail            <= tail + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_err <= 1'b0;
        end else if (mem_ack_i && (count == '0)) begin
            ack_err <= 1'b1;
        end
    end

    always_comb begin
        state_d = ST_RUN;
        if (full_block) begin
            state_d = ST_FULL_STALL;
        end else if (hit_ex || hit_pend) begin
            state_d = ST_LU_STALL;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if ((state_q != ST_RUN) && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (branch_taken_i && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

    assign pend_count_o = count;
    assign ack_err_o    = ack_err;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, x0 loads, full queue, branch override, stray ack, reset.
module tb_hazard_scoreboard;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
    logic       id_rs1_used_i, id_rs2_used_i;
    logic       ex_mem_read_i, ex_advance_i, mem_ack_i, branch_taken_i;
    logic       stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o, flush_ifid_o;
    logic [2:0] pend_count_o;
    logic       ack_err_o;
    logic [31:0] stall_cycles_o, flush_count_o;
    logic [1:0] dbg_state_o;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    hazard_scoreboard #(.REG_ADDR_WIDTH(5), .PEND_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_mem_read_i(ex_mem_read_i),
        .ex_advance_i(ex_advance_i), .mem_ack_i(mem_ack_i),
        .branch_taken_i(branch_taken_i),
        .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .stall_ex_o(stall_ex_o),
        .bubble_ex_o(bubble_ex_o), .flush_ifid_o(flush_ifid_o),
        .pend_count_o(pend_count_o), .ack_err_o(ack_err_o),
        .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o),
        .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic set_idle();
        id_rs1_addr_i = '0; id_rs2_addr_i = '0;
        id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0;
        ex_rd_addr_i = '0; ex_mem_read_i = 1'b0; ex_advance_i = 1'b0;
        mem_ack_i = 1'b0; branch_taken_i = 1'b0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic adv);
        ex_mem_read_i = 1'b1;
        ex_rd_addr_i  = rd;
        ex_advance_i  = adv;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        set_idle();
        rst_i = 1'b1;
        branch_taken_i = 1'b1;
        #2;
        check_val("rst_pend", 32'(pend_count_o), 0);
        check_val("rst_flush_gated", 32'(flush_ifid_o), 0);
        check_val("rst_bubble_gated", 32'(bubble_ex_o), 0);
        check_val("rst_ack_err", 32'(ack_err_o), 0);
        check_val("rst_flush_cnt", flush_count_o, 0);
        step();
        step();
        branch_taken_i = 1'b0;
        rst_i = 1'b0;

        // load-use on x5
        drive_load(5'd5, 1'b1);
        id_rs1_addr_i = 5'd5; id_rs1_used_i = 1'b1;
        #2;
        check_val("lu_ex_stall_if", 32'(stall_if_o), 1);
        check_val("lu_ex_bubble", 32'(bubble_ex_o), 1);
        check_val("lu_ex_stall_ex", 32'(stall_ex_o), 0);
        step();
        ex_mem_read_i = 1'b0; ex_advance_i = 1'b0;
        #2;
        check_val("lu_pend_cnt", 32'(pend_count_o), 1);
        check_val("lu_pend_stall", 32'(stall_if_o), 1);
        check_val("lu_state", 32'(dbg_state_o), 1);
        step();
        mem_ack_i = 1'b1;
        #2;
        check_val("lu_ack_no_wake", 32'(stall_if_o), 1);
        step();
        mem_ack_i = 1'b0;
        #2;
        check_val("lu_after_ack_stall", 32'(stall_if_o), 0);
        check_val("lu_after_ack_bubble", 32'(bubble_ex_o), 0);
        check_val("lu_after_ack_pend", 32'(pend_count_o), 0);
        check_val("lu_stall_cycles", stall_cycles_o, PERF ? 32'd2 : 32'd0);
        step();
        check_val("lu_state_run", 32'(dbg_state_o), 0);
        check_val("lu_stall_cycles_end", stall_cycles_o, PERF ? 32'd3 : 32'd0);

        // load to x0 with ID reading x0
        set_idle();
        drive_load(5'd0, 1'b1);
        id_rs1_used_i = 1'b1;
        #2;
        check_val("x0_ex_no_stall", 32'(stall_if_o), 0);
        step();
        ex_mem_read_i = 1'b0; ex_advance_i = 1'b0;
        #2;
        check_val("x0_pend", 32'(pend_count_o), 1);
        check_val("x0_pend_no_stall", 32'(stall_if_o), 0);
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        check_val("x0_drained", 32'(pend_count_o), 0);
        check_val("x0_no_ack_err", 32'(ack_err_o), 0);

        // fill the queue with rd 1..4
        set_idle();
        for (int k = 1; k <= 4; k++) begin
            drive_load(5'(k), 1'b1);
            step();
            exp_q.push_back(32'(k));
            check_val($sformatf("fill_pend_%0d", k), 32'(pend_count_o), exp_q.pop_front());
        end
        drive_load(5'd6, 1'b1);
        #2;
        check_val("full_stall_ex", 32'(stall_ex_o), 1);
        check_val("full_stall_if", 32'(stall_if_o), 1);
        check_val("full_bubble", 32'(bubble_ex_o), 0);
        step();
        check_val("full_pend_hold", 32'(pend_count_o), 4);
        check_val("full_state", 32'(dbg_state_o), 2);
        mem_ack_i = 1'b1;
        #2;
        check_val("full_ack_stall_ex", 32'(stall_ex_o), 0);
        check_val("full_ack_stall_if", 32'(stall_if_o), 0);
        step();
        set_idle();
        check_val("full_pushpop_pend", 32'(pend_count_o), 4);
        check_val("full_state_run", 32'(dbg_state_o), 0);
        check_val("full_stall_cycles", stall_cycles_o, PERF ? 32'd4 : 32'd0);
        id_rs2_addr_i = 5'd6; id_rs2_used_i = 1'b1;
        #2;
        check_val("full_pushed_rd6_hit", 32'(stall_id_o), 1);
        set_idle();
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        check_val("pre_rst_pend", 32'(pend_count_o), 3);

        // reset with three loads outstanding (rd 3,4,6)
        id_rs1_addr_i = 5'd3; id_rs1_used_i = 1'b1;
        #2;
        check_val("pre_rst_stall", 32'(stall_if_o), 1);
        rst_i = 1'b1;
        #1;
        check_val("mid_rst_pend", 32'(pend_count_o), 0);
        check_val("mid_rst_stall_if", 32'(stall_if_o), 0);
        check_val("mid_rst_bubble", 32'(bubble_ex_o), 0);
        step();
        check_val("mid_rst_state", 32'(dbg_state_o), 0);
        check_val("mid_rst_stall_cycles", stall_cycles_o, 0);
        rst_i = 1'b0;
        #2;
        check_val("post_rst_no_stall", 32'(stall_if_o), 0);

        // branch over a load-use hazard
        set_idle();
        drive_load(5'd7, 1'b1);
        id_rs1_addr_i = 5'd7; id_rs1_used_i = 1'b1;
        branch_taken_i = 1'b1;
        #2;
        check_val("br_flush", 32'(flush_ifid_o), 1);
        check_val("br_bubble", 32'(bubble_ex_o), 1);
        check_val("br_stall_if", 32'(stall_if_o), 0);
        check_val("br_stall_id", 32'(stall_id_o), 0);
        check_val("br_stall_ex", 32'(stall_ex_o), 0);
        step();
        set_idle();
        check_val("br_load_pushed", 32'(pend_count_o), 1);
        check_val("br_flush_cnt", flush_count_o, PERF ? 32'd1 : 32'd0);

        // stray acknowledge
        mem_ack_i = 1'b1;
        step();
        check_val("stray_pre_pend", 32'(pend_count_o), 0);
        check_val("stray_pre_err", 32'(ack_err_o), 0);
        step();
        mem_ack_i = 1'b0;
        check_val("stray_err_set", 32'(ack_err_o), 1);
        step();
        step();
        check_val("stray_err_sticky", 32'(ack_err_o), 1);
        rst_i = 1'b1;
        #1;
        check_val("stray_err_cleared", 32'(ack_err_o), 0);
        step();
        rst_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
